// File: rtl/trackball_counter.sv
// Trackball motion accumulator: synchronises and glitch-filters the four raw
// dir/clk lines, counts filtered steps per axis and holds a latched snapshot for CPU reads.
module trackball_counter #(
  parameter int FILTER_LEN = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flip,
  input  logic             h_dir_in,
  input  logic             h_clk_in,
  input  logic             v_dir_in,
  input  logic             v_clk_in,
  input  logic             latch,
  input  logic             sel,
  output logic [CNT_W-1:0] dout,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic             step_h,
  output logic             step_v
);

  localparam logic [3:0]  ST_MAX = 4'(FILTER_LEN - 1);
  localparam int unsigned H_DIR  = 0;
  localparam int unsigned H_CLK  = 1;
  localparam int unsigned V_DIR  = 2;
  localparam int unsigned V_CLK  = 3;

  logic [3:0]       raw, s1, s2, filt, upd;
  logic [3:0]       st [4];
  logic             rise_h, rise_v, up_h, up_v;
  logic [CNT_W-1:0] h_next, v_next, h_snap, v_snap;

  assign raw = {v_clk_in, v_dir_in, h_clk_in, h_dir_in};

  // upd marks the edge on which a line's filtered value takes the synced value
  always_comb begin
    upd = '0;
    for (int unsigned i = 0; i < 4; i++)
      upd[i] = (s2[i] != filt[i]) && (st[i] == ST_MAX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1   <= '0;
      s2   <= '0;
      filt <= '0;
      for (int unsigned i = 0; i < 4; i++) st[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int unsigned i = 0; i < 4; i++) begin
        if (upd[i]) begin
          filt[i] <= s2[i];
          st[i]   <= '0;
        end else if (s2[i] != filt[i]) begin
          st[i] <= st[i] + 4'd1;
        end else begin
          st[i] <= '0;
        end
      end
    end
  end

  // Direction comes from the pre-edge filtered value, so a same-edge dir change loses
  assign rise_h = upd[H_CLK] & s2[H_CLK];
  assign rise_v = upd[V_CLK] & s2[V_CLK];
  assign up_h   = filt[H_DIR] ^ flip;
  assign up_v   = filt[V_DIR] ^ flip;

  always_comb begin
    h_next = h_count;
    v_next = v_count;
    if (rise_h) h_next = up_h ? h_count + CNT_W'(1) : h_count - CNT_W'(1);
    if (rise_v) v_next = up_v ? v_count + CNT_W'(1) : v_count - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_count <= '0;
      v_count <= '0;
      h_snap  <= '0;
      v_snap  <= '0;
      step_h  <= 1'b0;
      step_v  <= 1'b0;
    end else begin
      h_count <= h_next;
      v_count <= v_next;
      step_h  <= rise_h;
      step_v  <= rise_v;
      if (latch) begin
        h_snap <= h_next;
        v_snap <= v_next;
      end
    end
  end

  assign dout = sel ? v_snap : h_snap;

endmodule

// File: tb/tb_trackball_counter.sv
// Bench for trackball_counter: directed scenarios with literal expectations plus
// random traffic, all outputs compared every cycle against a sample-history model.
module tb_trackball_counter;

  localparam int FL  = 4;
  localparam int CW  = 8;
  localparam int MOD = 1 << CW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flip, h_dir_in, h_clk_in, v_dir_in, v_clk_in, latch, sel;
  logic [CW-1:0] dout, h_count, v_count;
  logic          step_h, step_v;

  trackball_counter #(.FILTER_LEN(FL), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .flip(flip),
    .h_dir_in(h_dir_in), .h_clk_in(h_clk_in),
    .v_dir_in(v_dir_in), .v_clk_in(v_clk_in),
    .latch(latch), .sel(sel), .dout(dout),
    .h_count(h_count), .v_count(v_count),
    .step_h(step_h), .step_v(step_v)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Inputs as seen by the DUT at each rising edge
  logic [3:0] smp_raw;
  logic       smp_flip, smp_latch, smp_rst;
  initial forever begin
    @(posedge clk);
    smp_raw   = {v_clk_in, v_dir_in, h_clk_in, h_dir_in};
    smp_flip  = flip;
    smp_latch = latch;
    smp_rst   = reset_n;
  end

  // Model: each line's sample reaches the filter two edges late; the filtered
  // value flips once FL consecutive delayed samples disagree with it.
  int mlag1 [4], mlag2 [4], mf [4], mrun [4];
  int mh, mv, msh, msv, mstep_h, mstep_v;

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      mlag1[i] = 0; mlag2[i] = 0; mf[i] = 0; mrun[i] = 0;
    end
    mh = 0; mv = 0; msh = 0; msv = 0; mstep_h = 0; mstep_v = 0;
  endtask

  task automatic model_step();
    int nf [4];
    int rose [4];
    int seen;
    for (int i = 0; i < 4; i++) begin
      seen    = mlag2[i];
      mlag2[i] = mlag1[i];
      mlag1[i] = int'(smp_raw[i]);
      nf[i]   = mf[i];
      rose[i] = 0;
      if (seen != mf[i]) begin
        mrun[i]++;
        if (mrun[i] == FL) begin
          nf[i]   = seen;
          mrun[i] = 0;
          rose[i] = seen;
        end
      end else begin
        mrun[i] = 0;
      end
    end
    mstep_h = rose[1];
    mstep_v = rose[3];
    if (rose[1] != 0) mh = (mh + (((mf[0] != 0) != smp_flip) ? 1 : MOD - 1)) % MOD;
    if (rose[3] != 0) mv = (mv + (((mf[2] != 0) != smp_flip) ? 1 : MOD - 1)) % MOD;
    for (int i = 0; i < 4; i++) mf[i] = nf[i];
    if (smp_latch) begin
      msh = mh;
      msv = mv;
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(negedge clk);
      if (!reset_n) model_clear();
      else if (smp_rst) model_step();
      check("m_h_count", int'(h_count), mh);
      check("m_v_count", int'(v_count), mv);
      check("m_step_h",  int'(step_h),  mstep_h);
      check("m_step_v",  int'(step_v),  mstep_v);
      check("m_dout",    int'(dout),    sel ? msv : msh);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic hstep(input logic d);
    h_dir_in = d;
    repeat (2) tick();
    h_clk_in = 1'b1;
    repeat (6) tick();
    h_clk_in = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    reset_n = 1'b0;
    {flip, h_dir_in, h_clk_in, v_dir_in, v_clk_in, latch, sel} = '0;
    repeat (8) begin
      tick();
      {flip, h_dir_in, h_clk_in, v_dir_in, v_clk_in, latch, sel} = 7'($urandom);
    end
    repeat (6) tick();
    check("rst_h_count", int'(h_count), 0);
    check("rst_v_count", int'(v_count), 0);
    check("rst_step",    int'({step_h, step_v}), 0);
    check("rst_dout",    int'(dout), 0);
    {flip, h_dir_in, h_clk_in, v_dir_in, v_clk_in, latch, sel} = '0;
    tick();
    reset_n = 1'b1;
    repeat (20) tick();
    check("idle_h_count", int'(h_count), 0);

    h_dir_in = 1'b1;
    repeat (3) tick();
    h_clk_in = 1'b1;
    repeat (5) tick();
    check("lat_before", int'(step_h), 0);
    tick();
    check("lat_step",  int'(step_h), 1);
    check("lat_count", int'(h_count), 1);
    tick();
    check("lat_pulse_end", int'(step_h), 0);
    repeat (4) tick();
    h_clk_in = 1'b0;
    repeat (10) tick();
    check("fall_no_change", int'(h_count), 1);

    h_clk_in = 1'b1;
    repeat (3) tick();
    h_clk_in = 1'b0;
    repeat (10) tick();
    check("glitch3_reject", int'(h_count), 1);
    h_clk_in = 1'b1;
    repeat (4) tick();
    h_clk_in = 1'b0;
    repeat (10) tick();
    check("pulse4_accept", int'(h_count), 2);

    hstep(1'b0);
    hstep(1'b0);
    check("down_to_zero", int'(h_count), 0);
    hstep(1'b0);
    check("wrap_down", int'(h_count), 255);
    flip = 1'b1;
    hstep(1'b0);
    check("flip_wrap_up", int'(h_count), 0);
    flip = 1'b0;
    repeat (256) hstep(1'b1);
    check("wrap_256_up", int'(h_count), 0);

    h_dir_in = 1'b1;
    v_dir_in = 1'b0;
    repeat (3) tick();
    h_clk_in = 1'b1;
    v_clk_in = 1'b1;
    repeat (5) tick();
    latch = 1'b1;
    tick();
    latch = 1'b0;
    check("sim_step_h", int'(step_h), 1);
    check("sim_step_v", int'(step_v), 1);
    sel = 1'b0;
    #1 check("sim_dout_h", int'(dout), 1);
    sel = 1'b1;
    #1 check("sim_dout_v", int'(dout), 255);
    h_clk_in = 1'b0;
    v_clk_in = 1'b0;
    repeat (10) tick();

    h_dir_in = 1'b0;
    h_clk_in = 1'b1;
    repeat (8) tick();
    check("race_same_edge", int'(h_count), 2);
    h_clk_in = 1'b0;
    repeat (8) tick();
    h_dir_in = 1'b1;
    repeat (8) tick();
    h_dir_in = 1'b0;
    tick();
    h_clk_in = 1'b1;
    repeat (8) tick();
    check("race_dir_early", int'(h_count), 1);
    h_clk_in = 1'b0;
    repeat (8) tick();

    repeat (4000) begin
      if ($urandom_range(0, 5) == 0) h_dir_in = ~h_dir_in;
      if ($urandom_range(0, 5) == 0) h_clk_in = ~h_clk_in;
      if ($urandom_range(0, 5) == 0) v_dir_in = ~v_dir_in;
      if ($urandom_range(0, 5) == 0) v_clk_in = ~v_clk_in;
      if ($urandom_range(0, 199) == 0) flip = ~flip;
      latch   = ($urandom_range(0, 7) == 0);
      sel     = 1'($urandom_range(0, 1));
      reset_n = ($urandom_range(0, 999) != 0);
      tick();
    end
    reset_n = 1'b1;
    repeat (4) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
